// File: rtl/key_scan_ctrl.sv
// Front-panel key controller: syncs active-low keys, queues falls, and runs one
// shared debounce/hold timer per granted key, emitting press/long/release pulses.
module key_scan_ctrl #(
  parameter int NUM_KEYS = 4,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 24,
  parameter int DEB_CYC  = 1048575,
  parameter int LONG_CYC = 12500000
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] key_en,
  output logic                press_vld,
  output logic                long_vld,
  output logic                rel_vld,
  output logic [ID_W-1:0]     key_id,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, REL} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_KEYS - 1);

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_last_q, rr_last_d;
  logic [ID_W-1:0]     key_id_q, key_id_d;
  logic                long_done_q, long_done_d;
  logic                press_q, press_d, long_q, long_d, rel_q, rel_d;

  logic [NUM_KEYS-1:0] fall;
  logic                level;
  logic                grant;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     idx;

  assign fall  = s3_q & ~s2_q;
  assign level = s2_q[key_id_q];

  // Round-robin search: scanning from the far end lets the nearest pending key win.
  always_comb begin
    grant_id = rr_last_q;
    idx      = '0;
    for (int k = NUM_KEYS; k >= 1; k--) begin
      idx = ID_W'((int'(rr_last_q) + k) % NUM_KEYS);
      if (pend_q[idx]) grant_id = idx;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    s1_d = key_in;
    s2_d = s1_q;
    s3_d = s2_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!key_en[i])                           pend_d[i] = 1'b0;
      else if (grant && grant_id == ID_W'(i))   pend_d[i] = 1'b0;
      else if (fall[i])                         pend_d[i] = 1'b1;
      else                                      pend_d[i] = pend_q[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    rr_last_d   = rr_last_q;
    grant       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant       = 1'b1;
          rr_last_d   = grant_id;
          cnt_d       = '0;
          long_done_d = 1'b0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = level ? IDLE : HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (level) begin
          cnt_d   = '0;
          state_d = REL;
        end else begin
          if (cnt_q != LONG_LAST) cnt_d = cnt_q + 1'b1;
          if (cnt_q == LONG_LAST) long_done_d = 1'b1;
        end
      end
      REL: begin
        if (!level) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output logic, registered below so each pulse lasts exactly one cycle.
  always_comb begin
    press_d  = (state_q == SETTLE) && (cnt_q == DEB_LAST) && !level;
    long_d   = (state_q == HOLD) && !level && (cnt_q == LONG_LAST) && !long_done_q;
    rel_d    = (state_q == REL) && level && (cnt_q == DEB_LAST);
    key_id_d = grant ? grant_id : key_id_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= IDLE;
      s1_q        <= '1;
      s2_q        <= '1;
      s3_q        <= '1;
      pend_q      <= '0;
      cnt_q       <= '0;
      rr_last_q   <= ID_LAST;
      key_id_q    <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      long_q      <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      key_id_q    <= key_id_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      long_q      <= long_d;
      rel_q       <= rel_d;
    end
  end

  assign press_vld = press_q;
  assign long_vld  = long_q;
  assign rel_vld   = rel_q;
  assign key_id    = key_id_q;
  assign busy      = (state_q != IDLE);

endmodule
